// File: rtl/cpu_mc_pkg.sv
// Shared types and constants for the multi-cycle sequencer: FSM state encoding,
// instruction size and the jump/branch field layout used by the next-PC unit.
package cpu_mc_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        FWAIT  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_e;

    localparam int INST_BYTES  = 4;
    // Jump target field is ir[25:0]; branch offset is ir[15:0]; the jump keeps
    // pc_plus4 bits at and above REGION_LSB.
    localparam int JMP_FIELD_W = 26;
    localparam int OFF_FIELD_W = 16;
    localparam int REGION_LSB  = 28;

endpackage

// File: rtl/cpu_mc_npc.sv
// Combinational next-PC unit: jump > taken branch > sequential, all modulo 2^ADDR_W.
module cpu_mc_npc
    import cpu_mc_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]      pc,
    input  logic [JMP_FIELD_W-1:0] ir_field,
    input  logic                   dec_jmp,
    input  logic                   dec_branch,
    input  logic                   br_taken,
    output logic [ADDR_W-1:0]      next_pc
);

    logic [ADDR_W-1:0] pc_plus4_s;
    logic [ADDR_W-1:0] jmp_tgt_s;
    logic [ADDR_W-1:0] br_off_s;
    logic [ADDR_W-1:0] br_tgt_s;

    assign pc_plus4_s = pc + ADDR_W'(INST_BYTES);
    assign br_off_s   = {{(ADDR_W-OFF_FIELD_W-2){ir_field[OFF_FIELD_W-1]}},
                         ir_field[OFF_FIELD_W-1:0], 2'b00};
    assign br_tgt_s   = pc_plus4_s + br_off_s;

    // With a 28-bit address space there is no region above the jump field.
    generate
        if (ADDR_W > REGION_LSB) begin : g_region
            assign jmp_tgt_s = {pc_plus4_s[ADDR_W-1:REGION_LSB], ir_field, 2'b00};
        end else begin : g_no_region
            assign jmp_tgt_s = {ir_field, 2'b00};
        end
    endgenerate

    // Priority select of the next PC.
    always_comb begin
        next_pc = pc_plus4_s;
        if (dec_jmp) begin
            next_pc = jmp_tgt_s;
        end else if (dec_branch && br_taken) begin
            next_pc = br_tgt_s;
        end else begin
            next_pc = pc_plus4_s;
        end
    end

endmodule

// File: rtl/cpu_mc_seq.sv
// Multi-cycle sequencer: owns PC, IR, fetch/data handshakes, writeback timing and
// retire trace. Optional performance counters are enabled by CPU_MC_SEQ_PERF_EN.
module cpu_mc_seq
    import cpu_mc_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
`ifdef CPU_MC_SEQ_PERF_EN
    ,
    parameter int                PERF_W   = 32
`endif
) (
    input  logic              clk,
    input  logic              resetn,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_rvalid,
    input  logic [31:0]       inst_rdata,
    output logic [31:0]       ir,
    input  logic              dec_mem_rd,
    input  logic              dec_mem_wr,
    input  logic              dec_jmp,
    input  logic              dec_branch,
    input  logic              dec_wen,
    input  logic              dec_invalid,
    input  logic              br_taken,
    output logic              data_req,
    output logic              data_we,
    input  logic              data_ack,
    output logic              rf_we,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] debug_wb_pc,
    output logic              debug_wb_valid,
    output logic              halted
`ifdef CPU_MC_SEQ_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_cycles,
    output logic [PERF_W-1:0] perf_instret,
    output logic [PERF_W-1:0] perf_stall
`endif
);

    state_e            state_r, state_nx_s;
    logic [ADDR_W-1:0] pc_r, pc_nx_s;
    logic [ADDR_W-1:0] npc_r, npc_nx_s;
    logic [ADDR_W-1:0] npc_calc_s;
    logic [31:0]       ir_r, ir_nx_s;
    logic              inst_req_r, inst_req_nx_s;
    logic              data_req_r, data_req_nx_s;
    logic              data_we_r, data_we_nx_s;
    logic              rf_we_r, rf_we_nx_s;
    logic [ADDR_W-1:0] dbg_pc_r, dbg_pc_nx_s;
    logic              dbg_valid_r, dbg_valid_nx_s;
    logic              halted_r, halted_nx_s;

    cpu_mc_npc #(.ADDR_W(ADDR_W)) u_npc (
        .pc         (pc_r),
        .ir_field   (ir_r[JMP_FIELD_W-1:0]),
        .dec_jmp    (dec_jmp),
        .dec_branch (dec_branch),
        .br_taken   (br_taken),
        .next_pc    (npc_calc_s)
    );

    // Next-state and next-register-value logic; strobes are loaded one cycle
    // ahead so every output comes straight from a flop.
    always_comb begin
        state_nx_s     = state_r;
        pc_nx_s        = pc_r;
        npc_nx_s       = npc_r;
        ir_nx_s        = ir_r;
        inst_req_nx_s  = inst_req_r;
        data_req_nx_s  = data_req_r;
        data_we_nx_s   = data_we_r;
        rf_we_nx_s     = 1'b0;
        dbg_pc_nx_s    = dbg_pc_r;
        dbg_valid_nx_s = 1'b0;
        halted_nx_s    = halted_r;
        case (state_r)
            FETCH: begin
                inst_req_nx_s = 1'b1;
                state_nx_s    = FWAIT;
            end
            FWAIT: begin
                if (inst_rvalid) begin
                    ir_nx_s       = inst_rdata;
                    inst_req_nx_s = 1'b0;
                    state_nx_s    = DECODE;
                end else begin
                    state_nx_s    = FWAIT;
                end
            end
            DECODE: begin
                if (dec_invalid) begin
                    halted_nx_s = 1'b1;
                    state_nx_s  = HALT;
                end else begin
                    state_nx_s  = EXEC;
                end
            end
            EXEC: begin
                npc_nx_s = npc_calc_s;
                if (dec_mem_rd || dec_mem_wr) begin
                    data_req_nx_s = 1'b1;
                    data_we_nx_s  = dec_mem_wr;
                    state_nx_s    = MEM;
                end else begin
                    rf_we_nx_s    = dec_wen & ~dec_mem_wr;
                    state_nx_s    = WB;
                end
            end
            MEM: begin
                if (data_ack) begin
                    data_req_nx_s = 1'b0;
                    data_we_nx_s  = 1'b0;
                    rf_we_nx_s    = dec_wen & ~dec_mem_wr;
                    state_nx_s    = WB;
                end else begin
                    state_nx_s    = MEM;
                end
            end
            WB: begin
                pc_nx_s        = npc_r;
                dbg_pc_nx_s    = pc_r;
                dbg_valid_nx_s = 1'b1;
                state_nx_s     = FETCH;
            end
            HALT: begin
                inst_req_nx_s = 1'b0;
                data_req_nx_s = 1'b0;
                data_we_nx_s  = 1'b0;
                state_nx_s    = HALT;
            end
            default: begin
                inst_req_nx_s = 1'b0;
                data_req_nx_s = 1'b0;
                data_we_nx_s  = 1'b0;
                state_nx_s    = FETCH;
            end
        endcase
    end

    // Sequencer registers; reset wins over any in-flight handshake.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= FETCH;
            pc_r        <= RESET_PC;
            npc_r       <= RESET_PC;
            ir_r        <= 32'h0000_0000;
            inst_req_r  <= 1'b0;
            data_req_r  <= 1'b0;
            data_we_r   <= 1'b0;
            rf_we_r     <= 1'b0;
            dbg_pc_r    <= '0;
            dbg_valid_r <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            pc_r        <= pc_nx_s;
            npc_r       <= npc_nx_s;
            ir_r        <= ir_nx_s;
            inst_req_r  <= inst_req_nx_s;
            data_req_r  <= data_req_nx_s;
            data_we_r   <= data_we_nx_s;
            rf_we_r     <= rf_we_nx_s;
            dbg_pc_r    <= dbg_pc_nx_s;
            dbg_valid_r <= dbg_valid_nx_s;
            halted_r    <= halted_nx_s;
        end
    end

    assign inst_req       = inst_req_r;
    assign inst_addr      = pc_r;
    assign ir             = ir_r;
    assign data_req       = data_req_r;
    assign data_we        = data_we_r;
    assign rf_we          = rf_we_r;
    assign pc             = pc_r;
    assign debug_wb_pc    = dbg_pc_r;
    assign debug_wb_valid = dbg_valid_r;
    assign halted         = halted_r;

`ifdef CPU_MC_SEQ_PERF_EN
    logic [PERF_W-1:0] perf_cycles_r;
    logic [PERF_W-1:0] perf_instret_r;
    logic [PERF_W-1:0] perf_stall_r;
    logic              stall_s;

    assign stall_s = ((state_r == FWAIT) && !inst_rvalid) ||
                     ((state_r == MEM)   && !data_ack);

    // Wrapping counters, frozen while halted.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_cycles_r  <= '0;
            perf_instret_r <= '0;
            perf_stall_r   <= '0;
        end else if (state_r != HALT) begin
            perf_cycles_r  <= perf_cycles_r + PERF_W'(1);
            perf_instret_r <= (state_r == WB) ? perf_instret_r + PERF_W'(1) : perf_instret_r;
            perf_stall_r   <= stall_s ? perf_stall_r + PERF_W'(1) : perf_stall_r;
        end else begin
            perf_cycles_r  <= perf_cycles_r;
            perf_instret_r <= perf_instret_r;
            perf_stall_r   <= perf_stall_r;
        end
    end

    assign perf_cycles  = perf_cycles_r;
    assign perf_instret = perf_instret_r;
    assign perf_stall   = perf_stall_r;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_cpu_mc_seq.sv
// Directed self-checking bench for cpu_mc_seq (default build, ADDR_W=32, RESET_PC=0).
module tb_cpu_mc_seq;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_rvalid = 1'b0;
    logic [31:0] inst_rdata = 32'h0000_0000;
    logic [31:0] ir;
    logic        dec_mem_rd = 1'b0, dec_mem_wr = 1'b0, dec_jmp = 1'b0, dec_branch = 1'b0;
    logic        dec_wen = 1'b0, dec_invalid = 1'b0, br_taken = 1'b0;
    logic        data_req, data_we;
    logic        data_ack = 1'b0;
    logic        rf_we;
    logic [31:0] pc, debug_wb_pc;
    logic        debug_wb_valid, halted;

    int checks = 0;
    int failures = 0;

    cpu_mc_seq #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rvalid(inst_rvalid),
        .inst_rdata(inst_rdata), .ir(ir),
        .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr), .dec_jmp(dec_jmp),
        .dec_branch(dec_branch), .dec_wen(dec_wen), .dec_invalid(dec_invalid),
        .br_taken(br_taken),
        .data_req(data_req), .data_we(data_we), .data_ack(data_ack),
        .rf_we(rf_we), .pc(pc), .debug_wb_pc(debug_wb_pc),
        .debug_wb_valid(debug_wb_valid), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_dec(input logic j, input logic b, input logic t, input logic rd,
                           input logic wr, input logic wen, input logic inv);
        dec_jmp = j; dec_branch = b; br_taken = t;
        dec_mem_rd = rd; dec_mem_wr = wr; dec_wen = wen; dec_invalid = inv;
    endtask

    // One-cycle reset; returns at the falling edge of the first FETCH cycle.
    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; inst_rvalid = 1'b0; data_ack = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Runs one instruction starting at the falling edge of its FETCH cycle (k=0),
    // acting as instruction and data memory; returns at the retire-pulse cycle.
    task automatic do_instr(input logic [31:0] inst, input logic j, input logic b,
                            input logic t, input logic rd, input logic wr, input logic wen,
                            input int iwait, input int dwait,
                            output int retire_k, output int rf_cnt, output int rf_k,
                            output int ack_k, output int dreq_cnt, output int bad_cnt);
        logic [31:0] pc0;
        int iw, dw;
        pc0 = pc; iw = 0; dw = 0;
        retire_k = -1; rf_cnt = 0; rf_k = -1; ack_k = -1; dreq_cnt = 0; bad_cnt = 0;
        inst_rdata = inst;
        set_dec(j, b, t, rd, wr, wen, 1'b0);
        for (int k = 0; k < 64; k++) begin
            if (k > 0 && debug_wb_valid) begin
                retire_k = k;
                break;
            end
            if (inst_req) begin
                if (inst_addr !== pc0) bad_cnt++;
                inst_rvalid = (iw == iwait);
                iw++;
            end else begin
                inst_rvalid = 1'b0;
            end
            if (data_req) begin
                dreq_cnt++;
                if (data_we !== wr) bad_cnt++;
                data_ack = (dw == dwait);
                if (dw == dwait) ack_k = k;
                dw++;
            end else begin
                data_ack = 1'b0;
            end
            if (rf_we) begin
                rf_cnt++;
                rf_k = k;
            end
            @(negedge clk);
        end
        inst_rvalid = 1'b0;
        data_ack = 1'b0;
    endtask

    int rk, rc, rfk, ak, dq, bad, busy;

    initial begin
        // Reset state
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("rst_pc", pc, 32'h0);
        check("rst_ir", ir, 32'h0);
        check("rst_strobes", {inst_req, data_req, data_we, rf_we}, 4'b0000);
        check("rst_dbg", {debug_wb_valid, halted, debug_wb_pc}, 34'h0);
        resetn = 1'b1;

        // ALU op, 1-cycle memory
        do_instr(32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, rk, rc, rfk, ak, dq, bad);
        check("alu_retire_cycle", rk, 5);
        check("alu_addr_stable", bad, 0);
        check("alu_wb_pc", debug_wb_pc, 32'h0);
        check("alu_rf_pulses", rc, 1);
        check("alu_rf_in_wb", rfk, 4);
        check("alu_pc", pc, 32'h4);
        check("alu_ir", ir, 32'h0000_1234);

        // Jump from 0x4 to 0x100, then a fetch with 3 wait states
        do_instr(32'h0800_0040, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, rk, rc, rfk, ak, dq, bad);
        check("jmp_pc_100", pc, 32'h100);
        check("jmp_no_rf", rc, 0);
        do_instr(32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 0, rk, rc, rfk, ak, dq, bad);
        check("iwait_addr_stable", bad, 0);
        check("iwait_retire_cycle", rk, 8);
        check("iwait_wb_pc", debug_wb_pc, 32'h100);
        check("iwait_pc", pc, 32'h104);

        // Reach 0x1000_0000 via jump to 0x0FFF_FFFC, then jump within region 1
        do_instr(32'h03FF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, rk, rc, rfk, ak, dq, bad);
        check("jmp_pc_0ffffffc", pc, 32'h0FFF_FFFC);
        do_instr(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, rk, rc, rfk, ak, dq, bad);
        check("seq_pc_10000000", pc, 32'h1000_0000);
        do_instr(32'h0800_0040, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, rk, rc, rfk, ak, dq, bad);
        check("jmp_region_pc", pc, 32'h1000_0100);

        // Branches at 0x20
        do_reset();
        do_instr(32'h0000_0008, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, rk, rc, rfk, ak, dq, bad);
        check("jmp_pc_20", pc, 32'h20);
        do_instr(32'h0000_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, rk, rc, rfk, ak, dq, bad);
        check("br_taken_pc", pc, 32'h20);
        do_instr(32'h0000_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, rk, rc, rfk, ak, dq, bad);
        check("br_not_taken_pc", pc, 32'h24);
        do_instr(32'h0000_0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, rk, rc, rfk, ak, dq, bad);
        check("jmp_over_br_pc", pc, 32'h40);

        // Store with two wait states (dec_wen set but must be suppressed), then load
        do_instr(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 2, rk, rc, rfk, ak, dq, bad);
        check("st_req_cycles", dq, 3);
        check("st_we_ok", bad, 0);
        check("st_no_rf", rc, 0);
        check("st_retire_cycle", rk, 8);
        check("st_pc", pc, 32'h44);
        do_instr(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, rk, rc, rfk, ak, dq, bad);
        check("ld_we_ok", bad, 0);
        check("ld_rf_after_ack", rfk - ak, 1);
        check("ld_rf_pulses", rc, 1);
        check("ld_retire_cycle", rk, 6);
        do_instr(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0, rk, rc, rfk, ak, dq, bad);
        check("rdwr_store_wins", bad, 0);
        check("rdwr_no_rf", rc, 0);

        // Wrap-around: branch back to 0xFFFF_FFFC, then sequential to 0
        do_reset();
        do_instr(32'h0000_FFFE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, rk, rc, rfk, ak, dq, bad);
        check("br_back_pc", pc, 32'hFFFF_FFFC);
        do_instr(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, rk, rc, rfk, ak, dq, bad);
        check("wrap_pc", pc, 32'h0);
        check("wrap_wb_pc", debug_wb_pc, 32'hFFFF_FFFC);

        // Invalid instruction halts; strobes stay low with toggling handshakes
        do_reset();
        inst_rdata = 32'hFFFF_FFFF;
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            inst_rvalid = inst_req;
            @(negedge clk);
        end
        inst_rvalid = 1'b0;
        check("halt_set", halted, 1'b1);
        busy = 0;
        for (int k = 0; k < 10; k++) begin
            inst_rvalid = ~inst_rvalid;
            data_ack = ~data_ack;
            @(negedge clk);
            if (inst_req || data_req || rf_we || debug_wb_valid) busy++;
        end
        check("halt_quiet", busy, 0);
        check("halt_pc_frozen", pc, 32'h0);
        check("halt_sticky", halted, 1'b1);
        inst_rvalid = 1'b0; data_ack = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("halt_reset_halted", halted, 1'b0);
        check("halt_reset_pc", pc, 32'h0);
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("halt_reset_refetch", inst_req, 1'b1);

        // Reset while waiting in MEM
        do_reset();
        set_dec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            inst_rvalid = inst_req;
            @(negedge clk);
        end
        inst_rvalid = 1'b0;
        check("mem_req_before_rst", data_req, 1'b1);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("mem_rst_data_req", {data_req, data_we, rf_we}, 3'b000);
        check("mem_rst_pc", pc, 32'h0);
        @(negedge clk);
        check("mem_rst_fetch", {inst_req, inst_addr}, {1'b1, 32'h0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
